adder_sum_accumulator: RTL

Downstream stage of the 8-bit ripple adder: consumes each 9-bit adder result ({carry-out, sum}) through a valid/ready handshake. It accumulates a programmable number of results into a running total and presents the block total on a held output handshake. Intended for use as a running-sum / averaging front end behind the adder in the same tile.

---
 rtl/adder_sum_accumulator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//
// Sits downstream of the DW-bit ripple adder. It takes each {carry-out, sum} result over a
// valid/ready handshake and adds a programmable number of them into a running total. The
// finished block total is then held on an output handshake until the consumer takes it.
//
// Optional feature, selected at build time:
//   ADDER_ACC_SAT_EN  defined   : on the first carry out of bit AW-1 the accumulator clamps to
//                                 2^AW-1 and stays there for the rest of the block.
//                     undefined : the accumulator wraps modulo 2^AW.
//   out_ovf is set (sticky per block) in both builds.
//
// Parameters:
//   DW  adder sum width; the operand is DW+1 bits wide ({in_cout, in_sum})
//   AW  accumulator / result width (AW > DW+1)
//   CW  block-length field width; one block holds 1..2^CW samples
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   adder result present
//   in_ready   block can accept a sample this cycle (decoded from state only)
//   in_sum     adder sum
//   in_cout    adder carry-out, bit DW of the operand
//   len        samples per block, 0 encodes 2^CW; sampled on the first accept of a block
//   out_valid  block total available
//   out_ready  consumer takes the total
//   out_acc    block total
//   out_ovf    accumulation exceeded 2^AW-1 during this block
//   busy       block in progress (not idle)
module adder_sum_accumulator #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sum,
  input  logic          in_cout,
  input  logic [CW-1:0] len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  // Counter and length are one bit wider than the len field so that 2^CW is representable.
  localparam logic [CW:0] LenMax = {1'b1, {CW{1'b0}}};
  localparam logic [CW:0] CntOne = {{CW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW:0]   cnt_q, cnt_d;
  logic [CW:0]   len_q, len_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic [AW-1:0] operand;
  logic [CW:0]   len_eff;
  logic [CW:0]   cnt_inc;
  logic [AW:0]   sum_wide;
  logic          carry;
  logic [AW-1:0] acc_step;

  assign operand = {{(AW-DW-1){1'b0}}, in_cout, in_sum};
  assign len_eff = (len == '0) ? LenMax : {1'b0, len};
  assign cnt_inc = cnt_q + CntOne;

  // Bit AW of the widened sum is the carry that marks overflow.
  assign sum_wide = {1'b0, acc_q} + {1'b0, operand};
  assign carry    = sum_wide[AW];

`ifdef ADDER_ACC_SAT_EN
  // Once the block has overflowed it stays clamped, whatever is added later.
  assign acc_step = (ovf_q | carry) ? {AW{1'b1}} : sum_wide[AW-1:0];
`else
  assign acc_step = sum_wide[AW-1:0];
`endif

  // in_ready is a pure state decode; it never looks at in_valid or out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StAccum: in_ready = 1'b1;
      StDone:  out_valid = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          len_d   = len_eff;
          acc_d   = operand;
          cnt_d   = CntOne;
          ovf_d   = 1'b0;
          state_d = (len_eff == CntOne) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d = acc_step;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | carry;
          if (cnt_inc == len_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Driven straight from registers so the total stays put while the consumer stalls.
  assign out_acc = acc_q;
  assign out_ovf = ovf_q;

endmodule
